// File: rtl/sram_arbiter_if.sv
// Bus bundle for sram_arbiter: two requester ports plus the shared SRAM controller
// command interface. The master modport is the arbiter side, slave is the environment.
interface sram_arbiter_if #(
    parameter int AW = 20,
    parameter int DW = 8
);
    // Port 0: high-priority video fetch
    logic          req0;
    logic          rw0;
    logic [AW-1:0] addr0;
    logic [DW-1:0] wdata0;
    logic          gnt0;
    logic          rvalid0;

    // Port 1: general-purpose path
    logic          req1;
    logic          rw1;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wdata1;
    logic          gnt1;
    logic          rvalid1;

    // Shared read data, qualified by rvalid0/rvalid1
    logic [DW-1:0] rdata;

    // SRAM controller command interface
    logic          mem;
    logic          rw;
    logic          ready;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] data2ram;
    logic [DW-1:0] data2fpga;

    modport master (
        input  req0, rw0, addr0, wdata0,
        input  req1, rw1, addr1, wdata1,
        input  ready, data2fpga,
        output gnt0, rvalid0, gnt1, rvalid1, rdata,
        output mem, rw, sram_addr, data2ram
    );

    modport slave (
        output req0, rw0, addr0, wdata0,
        output req1, rw1, addr1, wdata1,
        output ready, data2fpga,
        input  gnt0, rvalid0, gnt1, rvalid1, rdata,
        input  mem, rw, sram_addr, data2ram
    );
endinterface

// File: rtl/sram_arbiter.sv
// Two-port arbiter in front of the single NTSC shield SRAM controller; port 0 has
// priority, port 1 starvation is bounded by MAX_WAIT. Optional counters: SRAM_ARB_STATS_EN.
module sram_arbiter #(
    parameter int AW       = 20,
    parameter int DW       = 8,
    parameter int MAX_WAIT = 4
) (
    input  logic           clk,
    input  logic           rst,
    sram_arbiter_if.master bus
`ifdef SRAM_ARB_STATS_EN
    ,
    output logic [15:0]    gnt_cnt0,
    output logic [15:0]    gnt_cnt1,
    output logic [15:0]    stall_cnt
`endif
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_BUSY  = 2'd2;

    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

    logic [1:0]    state_q,   state_d;
    logic          owner_q,   owner_d;
    logic [3:0]    wait_cnt_q, wait_cnt_d;
    logic          mem_q,     mem_d;
    logic          rw_q,      rw_d;
    logic [AW-1:0] addr_q,    addr_d;
    logic [DW-1:0] wdata_q,   wdata_d;
    logic          gnt0_q,    gnt0_d;
    logic          gnt1_q,    gnt1_d;
    logic          rvalid0_q, rvalid0_d;
    logic          rvalid1_q, rvalid1_d;
    logic [DW-1:0] rdata_q,   rdata_d;

    logic          pick1;
    logic          sel_rw;

    // Port 1 wins when alone, or when port 0 has used up its consecutive-grant allowance.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path can infer a latch.
        state_d    = state_q;
        owner_d    = owner_q;
        wait_cnt_d = wait_cnt_q;
        mem_d      = 1'b0;
        rw_d       = rw_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        gnt0_d     = 1'b0;
        gnt1_d     = 1'b0;
        rvalid0_d  = 1'b0;
        rvalid1_d  = 1'b0;
        rdata_d    = rdata_q;
        pick1      = bus.req1 && (!bus.req0 || (wait_cnt_q == MAX_WAIT_C));
        sel_rw     = pick1 ? bus.rw1 : bus.rw0;

        case (state_q)
            S_IDLE: begin
                if (bus.ready && (bus.req0 || bus.req1)) begin
                    owner_d = pick1;
                    rw_d    = sel_rw;
                    addr_d  = pick1 ? bus.addr1 : bus.addr0;
                    wdata_d = sel_rw ? '0 : (pick1 ? bus.wdata1 : bus.wdata0);
                    mem_d   = 1'b1;
                    gnt0_d  = !pick1;
                    gnt1_d  = pick1;
                    state_d = S_ISSUE;
                    if (pick1 || !bus.req1) begin
                        wait_cnt_d = '0;
                    end else if (wait_cnt_q < MAX_WAIT_C) begin
                        wait_cnt_d = wait_cnt_q + 4'd1;
                    end
                end
            end

            // The controller accepts the command this cycle; ready is not consulted here.
            S_ISSUE: begin
                state_d = S_BUSY;
            end

            S_BUSY: begin
                if (bus.ready) begin
                    if (rw_q) begin
                        rdata_d   = bus.data2fpga;
                        rvalid0_d = !owner_q;
                        rvalid1_d = owner_q;
                    end
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d    = S_IDLE;
                owner_d    = 1'b0;
                wait_cnt_d = '0;
                rw_d       = 1'b1;
                addr_d     = '0;
                wdata_d    = '0;
                rdata_d    = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            owner_q    <= 1'b0;
            wait_cnt_q <= '0;
            mem_q      <= 1'b0;
            rw_q       <= 1'b1;
            addr_q     <= '0;
            wdata_q    <= '0;
            gnt0_q     <= 1'b0;
            gnt1_q     <= 1'b0;
            rvalid0_q  <= 1'b0;
            rvalid1_q  <= 1'b0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            wait_cnt_q <= wait_cnt_d;
            mem_q      <= mem_d;
            rw_q       <= rw_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            gnt0_q     <= gnt0_d;
            gnt1_q     <= gnt1_d;
            rvalid0_q  <= rvalid0_d;
            rvalid1_q  <= rvalid1_d;
            rdata_q    <= rdata_d;
        end
    end

    assign bus.mem       = mem_q;
    assign bus.rw        = rw_q;
    assign bus.sram_addr = addr_q;
    assign bus.data2ram  = wdata_q;
    assign bus.gnt0      = gnt0_q;
    assign bus.gnt1      = gnt1_q;
    assign bus.rvalid0   = rvalid0_q;
    assign bus.rvalid1   = rvalid1_q;
    assign bus.rdata     = rdata_q;

`ifdef SRAM_ARB_STATS_EN
    logic [15:0] gnt_cnt0_q,  gnt_cnt0_d;
    logic [15:0] gnt_cnt1_q,  gnt_cnt1_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic        stalled;

    // Saturating counters; a stall is any pending request the arbiter cannot act on now.
    always_comb begin
        stalled     = (bus.req0 || bus.req1) && ((state_q != S_IDLE) || !bus.ready);
        gnt_cnt0_d  = gnt_cnt0_q;
        gnt_cnt1_d  = gnt_cnt1_q;
        stall_cnt_d = stall_cnt_q;
        if (gnt0_q && (gnt_cnt0_q != 16'hFFFF)) gnt_cnt0_d = gnt_cnt0_q + 16'd1;
        if (gnt1_q && (gnt_cnt1_q != 16'hFFFF)) gnt_cnt1_d = gnt_cnt1_q + 16'd1;
        if (stalled && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt_cnt0_q  <= '0;
            gnt_cnt1_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            gnt_cnt0_q  <= gnt_cnt0_d;
            gnt_cnt1_q  <= gnt_cnt1_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign gnt_cnt0  = gnt_cnt0_q;
    assign gnt_cnt1  = gnt_cnt1_q;
    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter: stimulus queues expected grants/read returns,
// a negedge monitor pops and compares them against a small SRAM controller model.
module tb_sram_arbiter;
    localparam int AW       = 20;
    localparam int DW       = 8;
    localparam int MAX_WAIT = 4;
    localparam int BUSY     = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    sram_arbiter_if #(.AW(AW), .DW(DW)) bus ();

`ifdef SRAM_ARB_STATS_EN
    logic [15:0] gnt_cnt0, gnt_cnt1, stall_cnt;
`endif

    sram_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus)
`ifdef SRAM_ARB_STATS_EN
        ,
        .gnt_cnt0  (gnt_cnt0),
        .gnt_cnt1  (gnt_cnt1),
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // SRAM controller model: fixed busy time, read data is a function of the address.
    logic          model_ready = 1'b1;
    logic          hold_low    = 1'b0;
    int            busy_left   = 0;
    logic [AW-1:0] op_addr     = '0;
    logic          op_rw       = 1'b1;
    logic [DW-1:0] rd_data     = '0;

    assign bus.ready     = model_ready && !hold_low;
    assign bus.data2fpga = rd_data;

    always @(posedge clk) begin
        if (bus.mem && bus.ready) begin
            model_ready <= 1'b0;
            busy_left   <= BUSY;
            op_addr     <= bus.sram_addr;
            op_rw       <= bus.rw;
        end else if (busy_left > 0) begin
            busy_left <= busy_left - 1;
            if (busy_left == 1) begin
                model_ready <= 1'b1;
                rd_data     <= op_rw ? (op_addr[7:0] ^ 8'hB5) : 8'hEE;
            end
        end
    end

    typedef struct {
        bit            port;
        bit            rw;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            at;
    } gnt_exp_t;

    typedef struct {
        bit            port;
        logic [DW-1:0] data;
    } rd_exp_t;

    gnt_exp_t exp_gnts[$];
    rd_exp_t  exp_rds[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a grant or read return.
    logic prev_gnt     = 1'b0;
    int   last_gnt_cyc = 0;

    always @(negedge clk) begin
        if (!rst) begin
            check("mem_matches_gnt", 32'(bus.mem), 32'(bus.gnt0 | bus.gnt1));
            if (bus.mem) check("mem_only_when_ready", 32'(bus.ready), 32'd1);
            if (bus.gnt0 || bus.gnt1) begin
                check("gnt_single_cycle", 32'(prev_gnt), 32'd0);
                check("gnt_not_both", 32'(bus.gnt0 & bus.gnt1), 32'd0);
                check("gnt_expected", 32'(exp_gnts.size() != 0), 32'd1);
                if (exp_gnts.size() != 0) begin
                    gnt_exp_t e;
                    e = exp_gnts.pop_front();
                    check("gnt_port", 32'(bus.gnt1), 32'(e.port));
                    check("gnt_rw", 32'(bus.rw), 32'(e.rw));
                    check("gnt_addr", 32'(bus.sram_addr), 32'(e.addr));
                    check("gnt_data2ram", 32'(bus.data2ram), 32'(e.wdata));
                    if (e.at >= 0) check("gnt_cycle", 32'(cyc), 32'(e.at));
                end
                last_gnt_cyc <= cyc;
            end
            if (bus.rvalid0 || bus.rvalid1) begin
                check("rvalid_not_both", 32'(bus.rvalid0 & bus.rvalid1), 32'd0);
                check("rd_expected", 32'(exp_rds.size() != 0), 32'd1);
                if (exp_rds.size() != 0) begin
                    rd_exp_t r;
                    r = exp_rds.pop_front();
                    check("rvalid_port", 32'(bus.rvalid1), 32'(r.port));
                    check("rdata", 32'(bus.rdata), 32'(r.data));
                    check("rd_latency", 32'(cyc - last_gnt_cyc), 32'(BUSY + 2));
                end
            end
        end
        prev_gnt <= bus.gnt0 | bus.gnt1;
    end

    task automatic drive_req(input bit port, input bit on, input bit rw,
                             input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        if (port) begin
            bus.req1 = on; bus.rw1 = rw; bus.addr1 = addr; bus.wdata1 = wdata;
        end else begin
            bus.req0 = on; bus.rw0 = rw; bus.addr0 = addr; bus.wdata0 = wdata;
        end
    endtask

    task automatic expect_gnt(input bit port, input bit rw, input logic [AW-1:0] addr,
                              input logic [DW-1:0] wdata, input int at);
        gnt_exp_t e;
        e.port  = port;
        e.rw    = rw;
        e.addr  = addr;
        e.wdata = rw ? '0 : wdata;
        e.at    = at;
        exp_gnts.push_back(e);
    endtask

    task automatic expect_rd(input bit port, input logic [DW-1:0] data);
        rd_exp_t r;
        r.port = port;
        r.data = data;
        exp_rds.push_back(r);
    endtask

    task automatic wait_gnt(input bit port, input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(port ? bus.gnt1 : bus.gnt0) && n < 100);
        check(name, 32'(port ? bus.gnt1 : bus.gnt0), 32'd1);
    endtask

    // Called at a negedge with the arbiter idle and the controller ready.
    task automatic request(input bit port, input bit rw, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata, input logic [DW-1:0] rdata_exp,
                           input string name);
        expect_gnt(port, rw, addr, wdata, cyc + 1);
        if (rw) expect_rd(port, rdata_exp);
        drive_req(port, 1'b1, rw, addr, wdata);
        wait_gnt(port, name);
        drive_req(port, 1'b0, rw, addr, wdata);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_mem"},       32'(bus.mem),       32'd0);
        check({tag, "_rw"},        32'(bus.rw),        32'd1);
        check({tag, "_sram_addr"}, 32'(bus.sram_addr), 32'd0);
        check({tag, "_data2ram"},  32'(bus.data2ram),  32'd0);
        check({tag, "_gnt0"},      32'(bus.gnt0),      32'd0);
        check({tag, "_gnt1"},      32'(bus.gnt1),      32'd0);
        check({tag, "_rvalid0"},   32'(bus.rvalid0),   32'd0);
        check({tag, "_rvalid1"},   32'(bus.rvalid1),   32'd0);
        check({tag, "_rdata"},     32'(bus.rdata),     32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.req0 = 1'b0; bus.rw0 = 1'b1; bus.addr0 = '0; bus.wdata0 = '0;
        bus.req1 = 1'b0; bus.rw1 = 1'b1; bus.addr1 = '0; bus.wdata1 = '0;
        rst = 1'b1;
        idle(3);
        check_reset("rst_init");
        rst = 1'b0;
        idle(2);

        // Port 1 read at 0x00010 returns 0xA5
        request(1'b1, 1'b1, 20'h00010, 8'h00, 8'hA5, "t1_gnt1");
        idle(8);

        // Port 0 write, no read return
        request(1'b0, 1'b0, 20'h80000, 8'h55, 8'h00, "t2_gnt0");
        idle(8);

        // Both held: order 0,0,0,0,1 repeating, one grant every 6 cycles
        begin
            int base;
            int seen;
            int n;
            base = cyc + 1;
            for (int k = 0; k < 10; k++) begin
                if (k == 4 || k == 9) expect_gnt(1'b1, 1'b0, 20'h00200, 8'h22, base + 6 * k);
                else                  expect_gnt(1'b0, 1'b0, 20'h00100, 8'h11, base + 6 * k);
            end
            drive_req(1'b0, 1'b1, 1'b0, 20'h00100, 8'h11);
            drive_req(1'b1, 1'b1, 1'b0, 20'h00200, 8'h22);
            seen = 0;
            n = 0;
            while (seen < 10 && n < 200) begin
                @(negedge clk);
                n++;
                if (bus.gnt0 || bus.gnt1) seen++;
            end
            check("t3_grant_count", 32'(seen), 32'd10);
            drive_req(1'b0, 1'b0, 1'b0, 20'h00100, 8'h11);
            drive_req(1'b1, 1'b0, 1'b0, 20'h00200, 8'h22);
            idle(8);
            check("t3_wait_cnt_cleared", 32'(dut.wait_cnt_q), 32'd0);
        end

        // Port 1 request while the controller holds ready low
        hold_low = 1'b1;
        drive_req(1'b1, 1'b1, 1'b1, 20'h00010, 8'h00);
        idle(10);
        expect_gnt(1'b1, 1'b1, 20'h00010, 8'h00, cyc + 1);
        expect_rd(1'b1, 8'hA5);
        hold_low = 1'b0;
        wait_gnt(1'b1, "t4_gnt1");
        drive_req(1'b1, 1'b0, 1'b1, 20'h00010, 8'h00);
        idle(8);

        // Reset during a port 0 read: read discarded, next issue waits for ready
        expect_gnt(1'b0, 1'b1, 20'h00020, 8'h00, cyc + 1);
        drive_req(1'b0, 1'b1, 1'b1, 20'h00020, 8'h00);
        wait_gnt(1'b0, "t5_gnt0_first");
        drive_req(1'b0, 1'b0, 1'b1, 20'h00020, 8'h00);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset("rst_mid");
        @(negedge clk);
        rst = 1'b0;
        expect_gnt(1'b0, 1'b1, 20'h00010, 8'h00, cyc + 3);
        expect_rd(1'b0, 8'hA5);
        drive_req(1'b0, 1'b1, 1'b1, 20'h00010, 8'h00);
        wait_gnt(1'b0, "t5_gnt0_after_rst");
        drive_req(1'b0, 1'b0, 1'b1, 20'h00010, 8'h00);
        idle(8);

`ifdef SRAM_ARB_STATS_EN
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        idle(2);
        for (int k = 0; k < 3; k++) begin
            request(1'b0, 1'b0, 20'h00300, 8'h33, 8'h00, "t6_gnt0");
            idle(6);
        end
        for (int k = 0; k < 2; k++) begin
            request(1'b1, 1'b0, 20'h00400, 8'h44, 8'h00, "t6_gnt1");
            idle(6);
        end
        check("t6_gnt_cnt0", 32'(gnt_cnt0), 32'd3);
        check("t6_gnt_cnt1", 32'(gnt_cnt1), 32'd2);
        force dut.gnt_cnt0_q = 16'hFFFF;
        @(negedge clk);
        release dut.gnt_cnt0_q;
        request(1'b0, 1'b0, 20'h00300, 8'h33, 8'h00, "t6_gnt0_sat");
        idle(6);
        check("t6_gnt_cnt0_saturated", 32'(gnt_cnt0), 32'hFFFF);
`endif

        check("gnt_queue_drained", 32'(exp_gnts.size()), 32'd0);
        check("rd_queue_drained", 32'(exp_rds.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
